// File: rtl/cache_controller.sv
`timescale 1ns/1ps
// Two-way set-associative write-through data cache: read hits return combinationally, and read misses and all writes stall through ready.
// Misses refill from the SRAM controller line on sram_cch_update and complete on sram_ready.
module cache_controller (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        sram_rd_en,
  output logic        sram_wr_en,
  output logic        sram_miss,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic [63:0] sram_rdata,
  input  logic        sram_ready,
  input  logic        sram_cch_update
);

  typedef enum logic [1:0] {IDLE, RD_MISS, WR_WAIT} state_t;

  state_t state, state_nxt;

  // Per-set valid and lru bits live in flat vectors so that reset can clear them in one step.
  logic [63:0] valid0, valid1, lru;
  logic [6:0]  tag0  [64];
  logic [6:0]  tag1  [64];
  logic [63:0] data0 [64];
  logic [63:0] data1 [64];
  logic [63:0] refill_buf;

  logic [5:0]  idx;
  logic [6:0]  tag_in;
  logic        word_sel;
  logic        hit0, hit1, hit, hit_way, victim;
  logic [63:0] hit_line;
  logic [31:0] hit_word;

  logic        rd_req, wr_req, miss_req;
  logic        lru_set, lru_val, wr_word, fill;

  assign idx      = addr[8:3];
  assign tag_in   = addr[15:9];
  assign word_sel = addr[2];

  assign hit0     = valid0[idx] && (tag0[idx] == tag_in);
  assign hit1     = valid1[idx] && (tag1[idx] == tag_in);
  assign hit      = hit0 || hit1;
  assign hit_way  = !hit0;
  assign hit_line = hit0 ? data0[idx] : data1[idx];
  assign hit_word = word_sel ? hit_line[63:32] : hit_line[31:0];
  assign victim   = !valid0[idx] ? 1'b0 : (!valid1[idx] ? 1'b1 : lru[idx]);

  assign sram_addr  = addr;
  assign sram_wdata = wdata;
  // Gating with rst makes the enables fall as soon as reset is asserted, without waiting for a clock edge.
  assign sram_rd_en = rd_req && rst;
  assign sram_wr_en = wr_req && rst;
  assign sram_miss  = miss_req && rst;

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    rdata     = '0;
    rd_req    = 1'b0;
    wr_req    = 1'b0;
    miss_req  = 1'b0;
    lru_set   = 1'b0;
    lru_val   = 1'b0;
    wr_word   = 1'b0;
    fill      = 1'b0;
    case (state)
      IDLE: begin
        if (wr_en) begin
          wr_req    = 1'b1;
          state_nxt = WR_WAIT;
          if (hit) begin
            wr_word = 1'b1;
            lru_set = 1'b1;
            lru_val = ~hit_way;
          end
        end else if (rd_en) begin
          if (hit) begin
            ready   = 1'b1;
            rdata   = hit_word;
            lru_set = 1'b1;
            lru_val = ~hit_way;
          end else begin
            rd_req    = 1'b1;
            miss_req  = 1'b1;
            state_nxt = RD_MISS;
          end
        end else begin
          ready = 1'b1;
        end
      end
      RD_MISS: begin
        rd_req   = 1'b1;
        miss_req = 1'b1;
        fill     = sram_cch_update;
        if (sram_ready) begin
          ready     = 1'b1;
          rdata     = word_sel ? refill_buf[63:32] : refill_buf[31:0];
          state_nxt = IDLE;
        end
      end
      WR_WAIT: begin
        wr_req = 1'b1;
        if (sram_ready) begin
          ready     = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      valid0     <= '0;
      valid1     <= '0;
      lru        <= '0;
      refill_buf <= '0;
    end else begin
      state <= state_nxt;
      if (lru_set) lru[idx] <= lru_val;
      if (fill) begin
        refill_buf <= sram_rdata;
        lru[idx]   <= ~victim;
        if (victim) valid1[idx] <= 1'b1;
        else        valid0[idx] <= 1'b1;
      end
    end
  end

  // Tag and data storage needs no reset; an entry is only ever read behind its valid bit.
  always_ff @(posedge clk) begin
    if (fill) begin
      if (victim) begin
        tag1[idx]  <= tag_in;
        data1[idx] <= sram_rdata;
      end else begin
        tag0[idx]  <= tag_in;
        data0[idx] <= sram_rdata;
      end
    end
    if (wr_word) begin
      if (hit_way) begin
        if (word_sel) data1[idx][63:32] <= wdata;
        else          data1[idx][31:0]  <= wdata;
      end else begin
        if (word_sel) data0[idx][63:32] <= wdata;
        else          data0[idx][31:0]  <= wdata;
      end
    end
  end

endmodule

// File: tb/tb_cache_controller.sv
`timescale 1ns/1ps
// Randomized and directed bench for cache_controller against a behavioural cache model and an SRAM-controller model.
module tb_cache_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_en, wr_en;
  logic [31:0] addr, wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        sram_rd_en, sram_wr_en, sram_miss;
  logic [31:0] sram_addr, sram_wdata;
  logic [63:0] sram_rdata;
  logic        sram_ready, sram_cch_update;

  int n_checks = 0;
  int n_fail   = 0;

  cache_controller dut (
    .clk             (clk),
    .rst             (rst),
    .rd_en           (rd_en),
    .wr_en           (wr_en),
    .addr            (addr),
    .wdata           (wdata),
    .rdata           (rdata),
    .ready           (ready),
    .sram_rd_en      (sram_rd_en),
    .sram_wr_en      (sram_wr_en),
    .sram_miss       (sram_miss),
    .sram_addr       (sram_addr),
    .sram_wdata      (sram_wdata),
    .sram_rdata      (sram_rdata),
    .sram_ready      (sram_ready),
    .sram_cch_update (sram_cch_update)
  );

  always #5 clk = ~clk;

  // SRAM controller model: cycle count since the request was first seen.
  int sram_cnt;
  always @(posedge clk or negedge rst) begin
    if (!rst) sram_cnt <= 0;
    else      sram_cnt <= ((sram_rd_en || sram_wr_en) && !sram_ready) ? sram_cnt + 1 : 0;
  end
  assign sram_cch_update = sram_rd_en && (sram_cnt == 4);
  assign sram_ready      = (sram_rd_en && sram_cnt == 5) || (sram_wr_en && sram_cnt == 3);
  assign sram_rdata      = {sram_addr | 32'h4, sram_addr};

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (sram_rd_en) chk_eq("rd_without_miss", {31'b0, sram_miss}, 32'd1);
  end

  // Behavioural cache model.
  bit          m_valid [64][2];
  logic [6:0]  m_tag   [64][2];
  logic [63:0] m_data  [64][2];
  int          m_lru   [64];

  function automatic void m_clear();
    for (int s = 0; s < 64; s++) begin
      m_valid[s][0] = 1'b0;
      m_valid[s][1] = 1'b0;
      m_lru[s]      = 0;
    end
  endfunction

  function automatic int m_lookup(input logic [15:0] a);
    int s = int'(a[8:3]);
    for (int w = 0; w < 2; w++)
      if (m_valid[s][w] && m_tag[s][w] == a[15:9]) return w;
    return -1;
  endfunction

  task automatic do_op(input bit r, input bit w, input logic [15:0] a, input logic [31:0] d,
                       output int stalls);
    int          way;
    int          s;
    int          v;
    int          exp_st;
    logic [31:0] exp_rd;
    logic [31:0] a32;
    bit          done;
    way    = m_lookup(a);
    s      = int'(a[8:3]);
    a32    = {16'h0, a};
    exp_st = w ? 3 : (way >= 0 ? 0 : 5);
    if (way >= 0) exp_rd = a[2] ? m_data[s][way][63:32] : m_data[s][way][31:0];
    else          exp_rd = a32;
    stalls = 0;
    done   = 1'b0;
    addr   = a32;
    wdata  = d;
    rd_en  = r;
    wr_en  = w;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (i == 0) begin
        chk_eq("sram_addr", sram_addr, a32);
        if (w) begin
          chk_eq("wr_sram_wr_en", {31'b0, sram_wr_en}, 32'd1);
          chk_eq("wr_sram_rd_en", {31'b0, sram_rd_en}, 32'd0);
          chk_eq("wr_sram_miss", {31'b0, sram_miss}, 32'd0);
          chk_eq("sram_wdata", sram_wdata, d);
        end else if (way < 0) begin
          chk_eq("miss_sram_rd_en", {31'b0, sram_rd_en}, 32'd1);
          chk_eq("miss_sram_miss", {31'b0, sram_miss}, 32'd1);
        end else begin
          chk_eq("hit_no_sram", {30'b0, sram_rd_en, sram_wr_en}, 32'd0);
        end
      end
      if (ready) done = 1'b1;
      else       stalls++;
    end
    chk_eq("done", {31'b0, done}, 32'd1);
    chk_eq(w ? "wr_stall" : "rd_stall", stalls, exp_st);
    if (!w) chk_eq("rdata", rdata, exp_rd);
    @(posedge clk);
    #1;
    rd_en = 1'b0;
    wr_en = 1'b0;
    if (w) begin
      if (way >= 0) begin
        if (a[2]) m_data[s][way][63:32] = d;
        else      m_data[s][way][31:0]  = d;
        m_lru[s] = 1 - way;
      end
    end else if (way >= 0) begin
      m_lru[s] = 1 - way;
    end else begin
      v = !m_valid[s][0] ? 0 : (!m_valid[s][1] ? 1 : m_lru[s]);
      m_valid[s][v] = 1'b1;
      m_tag[s][v]   = a[15:9];
      m_data[s][v]  = {a32 | 32'h4, a32};
      m_lru[s]      = 1 - v;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    m_clear();
    @(negedge clk);
    chk_eq("rst_ready", {31'b0, ready}, 32'd1);
    chk_eq("rst_rdata", rdata, 32'd0);
    chk_eq("rst_enables", {29'b0, sram_rd_en, sram_wr_en, sram_miss}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  int          st;
  int          kind;
  logic [15:0] ra;

  initial begin
    rd_en = 1'b0;
    wr_en = 1'b0;
    addr  = '0;
    wdata = '0;
    do_reset();

    do_op(1, 0, 16'h0010, 32'h0, st);
    chk_eq("first_miss_stall", st, 32'd5);
    do_op(1, 0, 16'h0014, 32'h0, st);
    chk_eq("reread_hit_stall", st, 32'd0);
    do_op(0, 1, 16'h0010, 32'hDEADBEEF, st);
    do_op(1, 0, 16'h0010, 32'h0, st);
    chk_eq("after_wr_hit_stall", st, 32'd0);
    chk_eq("after_wr_data", rdata, 32'hDEADBEEF);
    do_op(0, 1, 16'h0810, 32'h12345678, st);
    do_op(1, 0, 16'h0810, 32'h0, st);
    chk_eq("wr_miss_no_alloc", st, 32'd5);

    do_reset();
    do_op(1, 0, 16'h0210, 32'h0, st);
    do_op(1, 0, 16'h0410, 32'h0, st);
    do_op(1, 0, 16'h0210, 32'h0, st);
    chk_eq("t1_hit", st, 32'd0);
    do_op(1, 0, 16'h0610, 32'h0, st);
    chk_eq("t3_miss", st, 32'd5);
    do_op(1, 0, 16'h0210, 32'h0, st);
    chk_eq("t1_still_hit", st, 32'd0);
    do_op(1, 0, 16'h0410, 32'h0, st);
    chk_eq("t2_evicted", st, 32'd5);

    do_op(1, 1, 16'h0040, 32'hCAFEF00D, st);
    chk_eq("rdwr_as_write", st, 32'd3);

    // Reset two cycles into a miss.
    ra    = 16'h1238;
    addr  = {16'h0, ra};
    rd_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk_eq("midmiss_enables", {29'b0, sram_rd_en, sram_wr_en, sram_miss}, 32'd0);
    @(posedge clk);
    #1;
    rd_en = 1'b0;
    m_clear();
    @(negedge clk);
    chk_eq("midmiss_ready", {31'b0, ready}, 32'd1);
    chk_eq("midmiss_rdata", rdata, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    do_op(1, 0, ra, 32'h0, st);
    chk_eq("midmiss_remiss", st, 32'd5);

    for (int n = 0; n < 250; n++) begin
      kind = $urandom_range(0, 9);
      ra   = {7'($urandom_range(0, 3)), 6'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 2'b00};
      if (kind < 6)      do_op(1, 0, ra, 32'h0, st);
      else if (kind < 9) do_op(0, 1, ra, $urandom, st);
      else               do_op(1, 1, ra, $urandom, st);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
